pipe_adder: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder/subtractor. It generalises the single-bit full adder cell into a segmented carry chain.
- The carry chain is cut into WIDTH/SEG_W register stages. Throughput is one operation per clock.
- A valid/ready handshake on both sides allows back-pressure.
- Used as the arithmetic datapath primitive for counters and accumulators in later projects.

---
 rtl/pipe_adder_pkg.sv | 20 ++
 rtl/adder_seg.sv | 35 +++
 rtl/full_adder.sv | 15 +
 rtl/pipe_adder.sv | 158 +++++++++++++++
 tb/tb_pipe_adder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_SEG_W : default operand width and bits per stage
//   calc_stages()                 : number of register stages (WIDTH / SEG_W)
//   seg_w_divides()               : configuration legality check used at elaboration
package pipe_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_SEG_W = 4;

  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned seg_w);
    return width / seg_w;
  endfunction

  function automatic bit seg_w_divides(input int unsigned width,
                                       input int unsigned seg_w);
    return (seg_w != 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit ripple adder built from a chain of full_adder cells.
//   a, b       : segment operands
//   carry_in   : carry into bit 0 of the segment
//   sum        : segment sum
//   carry_out  : carry out of the segment MSB
//   carry_msb  : carry into the segment MSB (for signed overflow detection)
module adder_seg #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             carry_in,
  output logic [SEG_W-1:0] sum,
  output logic             carry_out,
  output logic             carry_msb
);

  logic [SEG_W:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign carry_out = c[SEG_W];
  assign carry_msb = c[SEG_W-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : operand bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor with a segmented carry chain.
// Each of STAGES = WIDTH/SEG_W stages resolves SEG_W bits and registers the
// carry; latency is STAGES cycles, throughput one op per clock.
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready = !stall)
//   addend_1, addend_2   : operands A and B
//   carry_in             : carry into bit 0 (ignored when sub_mode=1)
//   sub_mode             : 0 = A+B+carry_in, 1 = A-B (A + ~B + 1)
//   out_valid / out_ready: output handshake
//   sum, carry_out       : result modulo 2^WIDTH and carry out of the MSB
//   overflow             : signed overflow (carry into MSB ^ carry out)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] addend_1,
  input  logic [WIDTH-1:0] addend_2,
  input  logic             carry_in,
  input  logic             sub_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG_W);

  if (!seg_w_divides(WIDTH, SEG_W)) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign advance  = !stall;

  // Stage k carries only the operand bits still to be added (skew) and the
  // sum bits already resolved (deskew), so register widths shrink/grow by
  // SEG_W per stage and every sum bit lands in the final stage together.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IN_W   = WIDTH - k * SEG_W;
    localparam int unsigned DONE_W = (k + 1) * SEG_W;

    logic              v_in;
    logic              sub_in;
    logic              c_in;
    logic [IN_W-1:0]   a_in;
    logic [IN_W-1:0]   b_in;
    logic [SEG_W-1:0]  seg_b;
    logic [SEG_W-1:0]  seg_s;
    logic              seg_co;
    logic              seg_cmsb_unused;

    logic              v_q;
    logic              c_q;
    logic [DONE_W-1:0] s_q;

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign sub_in = sub_mode;
      assign c_in   = sub_mode | carry_in;
      assign a_in   = addend_1;
      assign b_in   = addend_2;
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_q;
      assign sub_in = g_stage[k-1].g_fwd.sub_q;
      assign c_in   = g_stage[k-1].c_q;
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
    end

    assign seg_b = b_in[SEG_W-1:0] ^ {SEG_W{sub_in}};

    adder_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a         (a_in[SEG_W-1:0]),
      .b         (seg_b),
      .carry_in  (c_in),
      .sum       (seg_s),
      .carry_out (seg_co),
      .carry_msb (seg_cmsb_unused)
    );

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= seg_co;
        end
      end
    end

    if (k == 0) begin : g_sum
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          s_q <= '0;
        end else if (advance && v_in) begin
          s_q <= seg_s;
        end
      end
    end else begin : g_sum
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          s_q <= '0;
        end else if (advance && v_in) begin
          s_q <= {seg_s, g_stage[k-1].s_q};
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic                  sub_q;
      logic [IN_W-SEG_W-1:0] a_q;
      logic [IN_W-SEG_W-1:0] b_q;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sub_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
        end else if (advance && v_in) begin
          sub_q <= sub_in;
          a_q   <= a_in[IN_W-1:SEG_W];
          b_q   <= b_in[IN_W-1:SEG_W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= seg_co ^ seg_cmsb_unused;
        end
      end

      assign out_valid = v_q;
      assign sum       = s_q;
      assign carry_out = c_q;
      assign overflow  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SEG_W  = 4;
  localparam int unsigned STAGES = WIDTH / SEG_W;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] addend_1;
  logic [WIDTH-1:0] addend_2;
  logic             carry_in;
  logic             sub_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  pipe_adder #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addend_1  (addend_1),
    .addend_2  (addend_2),
    .carry_in  (carry_in),
    .sub_mode  (sub_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: plain integer arithmetic in WIDTH+1 bits; signed overflow
  // from operand/result signs.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    exp_t             e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    logic [WIDTH-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = {1'b0, {(WIDTH-1){1'b1}}};
    corners[3] = {1'b1, {(WIDTH-1){1'b0}}};
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
    return WIDTH'($urandom);
  endfunction

  task automatic rand_op();
    addend_1 = rand_operand();
    addend_2 = rand_operand();
    carry_in = 1'($urandom);
    sub_mode = 1'($urandom);
  endtask

  // Scoreboard push on every input transfer.
  always @(negedge sys_clk) begin
    if (!sys_rst && in_valid && in_ready) begin
      exp_q.push_back(model(addend_1, addend_2, carry_in, sub_mode));
    end
  end

  // Monitor: pop and compare on every output transfer.
  always @(negedge sys_clk) begin
    if (!sys_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual sum=%h required=none", sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_sum", 32'(sum), 32'(mon_e.sum));
        check("res_cout", 32'(carry_out), 32'(mon_e.cout));
        check("res_ovf", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(posedge sys_clk); #1;
    addend_1  = a;
    addend_2  = b;
    carry_in  = cin;
    sub_mode  = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (i > 0) begin
        @(posedge sys_clk); #1;
      end
      check("latency_valid", 32'(out_valid), 32'(i == STAGES - 1));
    end
    check("dir_sum", 32'(sum), 32'(es));
    check("dir_cout", 32'(carry_out), 32'(ec));
    check("dir_ovf", 32'(overflow), 32'(eo));
  endtask

  initial begin
    int acc;
    int cyc;
    int stall_cnt;
    bit need_new;

    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    addend_1  = '0;
    addend_2  = '0;
    carry_in  = 1'b0;
    sub_mode  = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    sys_rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    directed(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h8000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back stream of 8 ops with a 3-cycle downstream stall.
    @(posedge sys_clk); #1;
    acc       = 0;
    stall_cnt = 0;
    need_new  = 1'b1;
    for (int c = 0; c < 60; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      in_valid  = (acc < 8);
      if (in_valid && need_new) begin
        rand_op();
        need_new = 1'b0;
      end
      @(negedge sys_clk);
      if (!out_ready && out_valid) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        stall_cnt++;
      end
      if (in_valid && in_ready) begin
        acc++;
        need_new = 1'b1;
      end
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
    check("stream_accepted", 32'(acc), 32'd8);
    check("stream_stalls", 32'(stall_cnt), 32'd3);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      addend_1[WIDTH-1] = 1'b1;
      in_valid = 1'b1;
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
    sys_rst  = 1'b1;
    exp_q.delete();
    @(posedge sys_clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(carry_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    sys_rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2 * STAGES; i++) begin
      @(negedge sys_clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomised mixed add/sub with random handshakes.
    @(posedge sys_clk); #1;
    acc      = 0;
    cyc      = 0;
    need_new = 1'b1;
    while (acc < 10000 && cyc < 80000) begin
      if (need_new) begin
        rand_op();
        need_new = 1'b0;
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge sys_clk);
      if (in_valid && in_ready) begin
        acc++;
        need_new = 1'b1;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_accepted", 32'(acc), 32'd10000);

    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge sys_clk); #1;
    end
    @(negedge sys_clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
